// File: rtl/weapon_pkg.sv
// Shared weapon/monster definitions: sprite state codes, facing directions
// and default sprite geometry. No ports; imported by the weapon blocks and
// by the monster module.
package weapon_pkg;

  typedef enum logic [3:0] {
    ST_WINDUP   = 4'h0,
    ST_ACTIVE   = 4'h1,
    ST_COOLDOWN = 4'h2,
    ST_IDLE     = 4'hf
  } weapon_state_e;

  localparam logic [1:0] DIR_R = 2'd0;
  localparam logic [1:0] DIR_L = 2'd1;
  localparam logic [1:0] DIR_D = 2'd2;
  localparam logic [1:0] DIR_U = 2'd3;

  localparam int DEF_REACH    = 16;
  localparam int DEF_HIT_SIZE = 16;
  localparam int DEF_MON_SIZE = 16;

  // 10-bit screen coordinate offset by +/- delta, clamped to 0..1023
  function automatic logic [9:0] coord_add_sat(input logic [9:0] base,
                                               input logic [9:0] delta);
    logic [10:0] sum;
    sum = {1'b0, base} + {1'b0, delta};
    return sum[10] ? 10'h3ff : sum[9:0];
  endfunction

  function automatic logic [9:0] coord_sub_sat(input logic [9:0] base,
                                               input logic [9:0] delta);
    return (base < delta) ? 10'h000 : (base - delta);
  endfunction

endpackage

// File: rtl/hitbox_overlap.sv
// Axis-aligned box overlap test.
// Ports: a_h/a_v/a_size and b_h/b_v/b_size describe two square boxes by
// origin and side length; overlap is high when their interiors intersect.
// Touching edges do not count. Sums are done in 11 bits so boxes near the
// right/bottom screen edge do not wrap.
module hitbox_overlap (
  input  logic [9:0] a_h,
  input  logic [9:0] a_v,
  input  logic [9:0] a_size,
  input  logic [9:0] b_h,
  input  logic [9:0] b_v,
  input  logic [9:0] b_size,
  output logic       overlap
);

  logic [10:0] a_h_end, a_v_end, b_h_end, b_v_end;

  always_comb begin
    a_h_end = {1'b0, a_h} + {1'b0, a_size};
    a_v_end = {1'b0, a_v} + {1'b0, a_size};
    b_h_end = {1'b0, b_h} + {1'b0, b_size};
    b_v_end = {1'b0, b_v} + {1'b0, b_size};
    overlap = ({1'b0, a_h} < b_h_end) && ({1'b0, b_h} < a_h_end) &&
              ({1'b0, a_v} < b_v_end) && ({1'b0, b_v} < a_v_end);
  end

endmodule

// File: rtl/weapon_attack.sv
// Player weapon controller: attack press -> WINDUP -> ACTIVE -> COOLDOWN.
// Ports: clk, rst (async, active-low), stage (0/f = no play), attack_btn,
// player_pos_h/v, player_dir, monster_pos_h/v, monster_is_dead in;
// weapon_state, hitbox_h/v, enable_weapon_collision, weapon_collision,
// hit_count out.
//
// state    | meaning
// IDLE     | weapon hidden, waiting for a press edge
// WINDUP   | swing started, hitbox latched, no collision yet
// ACTIVE   | hitbox live, at most one hit pulse per swing
// COOLDOWN | swing finished, presses ignored
module weapon_attack
  import weapon_pkg::*;
#(
  parameter int WINDUP_CYC   = 4,
  parameter int ACTIVE_CYC   = 16,
  parameter int COOLDOWN_CYC = 32,
  parameter int REACH        = DEF_REACH,
  parameter int HIT_SIZE     = DEF_HIT_SIZE,
  parameter int MON_SIZE     = DEF_MON_SIZE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] stage,
  input  logic       attack_btn,
  input  logic [9:0] player_pos_h,
  input  logic [9:0] player_pos_v,
  input  logic [1:0] player_dir,
  input  logic [9:0] monster_pos_h,
  input  logic [9:0] monster_pos_v,
  input  logic       monster_is_dead,
  output logic [3:0] weapon_state,
  output logic [9:0] hitbox_h,
  output logic [9:0] hitbox_v,
  output logic       enable_weapon_collision,
  output logic       weapon_collision,
  output logic [7:0] hit_count
);

  localparam logic [5:0] WINDUP_LD   = 6'(WINDUP_CYC - 1);
  localparam logic [5:0] ACTIVE_LD   = 6'(ACTIVE_CYC - 1);
  localparam logic [5:0] COOLDOWN_LD = 6'(COOLDOWN_CYC - 1);
  localparam logic [9:0] REACH_W     = 10'(REACH);
  localparam logic [9:0] HIT_W       = 10'(HIT_SIZE);
  localparam logic [9:0] MON_W       = 10'(MON_SIZE);

  weapon_state_e state_q;
  logic [5:0]    phase_cnt;
  logic          btn_prev;
  logic          hit_done;
  logic          press, play, overlap, hit_now;
  logic [9:0]    next_hb_h, next_hb_v;

  assign weapon_state = state_q;
  assign press        = attack_btn & ~btn_prev;
  assign play         = (stage != 4'h0) && (stage != 4'hf);
  assign hit_now      = (state_q == ST_ACTIVE) & overlap & ~monster_is_dead & ~hit_done;

  // Hitbox placed in front of the player, clamped to the screen
  always_comb begin
    next_hb_h = player_pos_h;
    next_hb_v = player_pos_v;
    case (player_dir)
      DIR_R:   next_hb_h = coord_add_sat(player_pos_h, REACH_W);
      DIR_L:   next_hb_h = coord_sub_sat(player_pos_h, REACH_W);
      DIR_D:   next_hb_v = coord_add_sat(player_pos_v, REACH_W);
      default: next_hb_v = coord_sub_sat(player_pos_v, REACH_W);
    endcase
  end

  hitbox_overlap u_overlap (
    .a_h    (hitbox_h),
    .a_v    (hitbox_v),
    .a_size (HIT_W),
    .b_h    (monster_pos_h),
    .b_v    (monster_pos_v),
    .b_size (MON_W),
    .overlap(overlap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q                 <= ST_IDLE;
      phase_cnt               <= '0;
      btn_prev                <= 1'b1;   // held-through-reset button must not fire
      hit_done                <= 1'b0;
      hitbox_h                <= '0;
      hitbox_v                <= '0;
      enable_weapon_collision <= 1'b0;
      weapon_collision        <= 1'b0;
      hit_count               <= '0;
    end else begin
      btn_prev <= attack_btn;
      if (!play) begin
        state_q                 <= ST_IDLE;
        phase_cnt               <= '0;
        hit_done                <= 1'b0;
        hitbox_h                <= '0;
        hitbox_v                <= '0;
        enable_weapon_collision <= 1'b0;
        weapon_collision        <= 1'b0;
      end else begin
        enable_weapon_collision <= (state_q == ST_ACTIVE);
        weapon_collision        <= hit_now;
        if (hit_now) begin
          hit_done <= 1'b1;
          if (hit_count != 8'hff) hit_count <= hit_count + 8'd1;
        end
        case (state_q)
          ST_IDLE: begin
            if (press) begin
              state_q   <= ST_WINDUP;
              phase_cnt <= WINDUP_LD;
              hit_done  <= 1'b0;
              hitbox_h  <= next_hb_h;
              hitbox_v  <= next_hb_v;
            end
          end
          ST_WINDUP: begin
            if (phase_cnt == 6'd0) begin
              state_q   <= ST_ACTIVE;
              phase_cnt <= ACTIVE_LD;
            end else begin
              phase_cnt <= phase_cnt - 6'd1;
            end
          end
          ST_ACTIVE: begin
            if (phase_cnt == 6'd0) begin
              state_q   <= ST_COOLDOWN;
              phase_cnt <= COOLDOWN_LD;
            end else begin
              phase_cnt <= phase_cnt - 6'd1;
            end
          end
          ST_COOLDOWN: begin
            if (phase_cnt == 6'd0) state_q <= ST_IDLE;
            else                   phase_cnt <= phase_cnt - 6'd1;
          end
          default: begin
            state_q   <= ST_IDLE;
            phase_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_weapon_attack.sv
module tb_weapon_attack;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] stage = 4'h1;
  logic       attack_btn = 1'b0;
  logic [9:0] player_pos_h = '0, player_pos_v = '0;
  logic [1:0] player_dir = '0;
  logic [9:0] monster_pos_h = 10'd500, monster_pos_v = 10'd500;
  logic       monster_is_dead = 1'b0;
  logic [3:0] weapon_state;
  logic [9:0] hitbox_h, hitbox_v;
  logic       enable_weapon_collision, weapon_collision;
  logic [7:0] hit_count;

  weapon_attack dut (
    .clk(clk), .rst(rst), .stage(stage), .attack_btn(attack_btn),
    .player_pos_h(player_pos_h), .player_pos_v(player_pos_v), .player_dir(player_dir),
    .monster_pos_h(monster_pos_h), .monster_pos_v(monster_pos_v),
    .monster_is_dead(monster_is_dead), .weapon_state(weapon_state),
    .hitbox_h(hitbox_h), .hitbox_v(hitbox_v),
    .enable_weapon_collision(enable_weapon_collision),
    .weapon_collision(weapon_collision), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] ph, pv;
    logic [1:0] dir;
    logic [9:0] mh, mv;
    logic       dead;
    logic [9:0] eh, ev;
    logic       pulse;
  } vec_t;

  typedef struct {
    int eh, ev, pulses, pcyc, hc;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   model_hc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected state code k cycles after the press edge with default timing
  function automatic int exp_state(input int k);
    if (k <= 0)  return 15;
    if (k <= 4)  return 0;
    if (k <= 20) return 1;
    if (k <= 52) return 2;
    return 15;
  endfunction

  // One full swing (53 cycles). Optionally moves the monster onto the
  // default hitbox after cycle move_k, and pulses the button at press_k.
  task automatic run_swing(input int move_k, input int press_k,
                           output int oh, output int ov, output int pulses,
                           output int pcyc, output int seq_err,
                           output int en_n, output int en_first);
    @(negedge clk);
    attack_btn = 1'b1;
    oh = 0; ov = 0; pulses = 0; pcyc = -1; seq_err = 0; en_n = 0; en_first = -1;
    for (int k = 1; k <= 53; k++) begin
      @(negedge clk);
      if (k == 1) begin
        attack_btn = 1'b0;
        oh = int'(hitbox_h);
        ov = int'(hitbox_v);
      end
      if (int'(weapon_state) != exp_state(k)) seq_err++;
      if (enable_weapon_collision) begin
        en_n++;
        if (en_first < 0) en_first = k;
      end
      if (weapon_collision) begin
        pulses++;
        if (pcyc < 0) pcyc = k;
      end
      if (k == move_k) begin
        monster_pos_h = 10'd120;
        monster_pos_v = 10'd124;
      end
      if (k == press_k)     attack_btn = 1'b1;
      if (k == press_k + 1) attack_btn = 1'b0;
    end
  endtask

  initial begin
    int oh, ov, pulses, pcyc, seq_err, en_n, en_first, entries, hc_before;
    exp_t e;
    logic [3:0] prev_st;

    vecs[0]  = '{10'd100, 10'd120, 2'd0, 10'd120, 10'd124, 1'b0, 10'd116, 10'd120, 1'b1};
    vecs[1]  = '{10'd100, 10'd120, 2'd0, 10'd132, 10'd120, 1'b0, 10'd116, 10'd120, 1'b0};
    vecs[2]  = '{10'd100, 10'd120, 2'd0, 10'd131, 10'd120, 1'b0, 10'd116, 10'd120, 1'b1};
    vecs[3]  = '{10'd10,  10'd50,  2'd1, 10'd0,   10'd50,  1'b1, 10'd0,   10'd50,  1'b0};
    vecs[4]  = '{10'd10,  10'd50,  2'd1, 10'd0,   10'd50,  1'b0, 10'd0,   10'd50,  1'b1};
    vecs[5]  = '{10'd200, 10'd300, 2'd2, 10'd200, 10'd316, 1'b0, 10'd200, 10'd316, 1'b1};
    vecs[6]  = '{10'd5,   10'd8,   2'd3, 10'd300, 10'd300, 1'b0, 10'd5,   10'd0,   1'b0};
    vecs[7]  = '{10'd1020,10'd40,  2'd0, 10'd1010,10'd40,  1'b0, 10'd1023,10'd40,  1'b1};
    vecs[8]  = '{10'd500, 10'd1015,2'd2, 10'd0,   10'd0,   1'b0, 10'd500, 10'd1023,1'b0};
    vecs[9]  = '{10'd100, 10'd120, 2'd1, 10'd84,  10'd135, 1'b0, 10'd84,  10'd120, 1'b1};
    vecs[10] = '{10'd100, 10'd120, 2'd1, 10'd84,  10'd136, 1'b0, 10'd84,  10'd120, 1'b0};

    // Reset state while rst is held low
    #12;
    chk("rst_state", int'(weapon_state), 15);
    chk("rst_enable", int'(enable_weapon_collision), 0);
    chk("rst_pulse", int'(weapon_collision), 0);
    chk("rst_hitbox", int'({hitbox_h, hitbox_v}), 0);
    chk("rst_hit_count", int'(hit_count), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven swings with a scoreboard of expected results
    foreach (vecs[i]) begin
      player_pos_h = vecs[i].ph;  player_pos_v = vecs[i].pv;
      player_dir = vecs[i].dir;
      monster_pos_h = vecs[i].mh; monster_pos_v = vecs[i].mv;
      monster_is_dead = vecs[i].dead;
      if (vecs[i].pulse) model_hc++;
      sb.push_back('{int'(vecs[i].eh), int'(vecs[i].ev), int'(vecs[i].pulse),
                     vecs[i].pulse ? 6 : -1, model_hc});
      run_swing(-1, -1, oh, ov, pulses, pcyc, seq_err, en_n, en_first);
      e = sb.pop_front();
      chk($sformatf("v%0d_hitbox_h", i), oh, e.eh);
      chk($sformatf("v%0d_hitbox_v", i), ov, e.ev);
      chk($sformatf("v%0d_pulses", i), pulses, e.pulses);
      chk($sformatf("v%0d_pulse_cycle", i), pcyc, e.pcyc);
      chk($sformatf("v%0d_hit_count", i), int'(hit_count), e.hc);
      chk($sformatf("v%0d_phase_seq_errs", i), seq_err, 0);
      chk($sformatf("v%0d_enable_cycles", i), en_n, 16);
      chk($sformatf("v%0d_enable_first", i), en_first, 6);
    end
    monster_is_dead = 1'b0;
    player_pos_h = 10'd100; player_pos_v = 10'd120; player_dir = 2'd0;

    // Button held 100 cycles -> exactly one swing
    monster_pos_h = 10'd500; monster_pos_v = 10'd500;
    @(negedge clk);
    attack_btn = 1'b1;
    entries = 0;
    prev_st = weapon_state;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (prev_st == 4'hf && weapon_state == 4'h0) entries++;
      prev_st = weapon_state;
    end
    attack_btn = 1'b0;
    chk("held_btn_swings", entries, 1);
    chk("held_btn_idle", int'(weapon_state), 15);

    // Press during COOLDOWN ignored, then a fresh press starts a new swing
    run_swing(-1, 30, oh, ov, pulses, pcyc, seq_err, en_n, en_first);
    chk("cooldown_press_seq_errs", seq_err, 0);
    run_swing(-1, -1, oh, ov, pulses, pcyc, seq_err, en_n, en_first);
    chk("repress_seq_errs", seq_err, 0);

    // Overlap appearing in the last ACTIVE cycle still pulses in cycle 21
    monster_pos_h = 10'd500; monster_pos_v = 10'd500;
    run_swing(20, -1, oh, ov, pulses, pcyc, seq_err, en_n, en_first);
    model_hc++;
    chk("late_overlap_pulses", pulses, 1);
    chk("late_overlap_cycle", pcyc, 21);
    chk("late_overlap_hit_count", int'(hit_count), model_hc);

    // Overlap appearing only in COOLDOWN never pulses
    monster_pos_h = 10'd500; monster_pos_v = 10'd500;
    run_swing(21, -1, oh, ov, pulses, pcyc, seq_err, en_n, en_first);
    chk("cooldown_overlap_pulses", pulses, 0);

    // Stage forced to 0 mid-ACTIVE
    monster_pos_h = 10'd500; monster_pos_v = 10'd500;
    @(negedge clk);
    attack_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      attack_btn = 1'b0;
    end
    chk("pre_gate_enable", int'(enable_weapon_collision), 1);
    stage = 4'h0;
    @(negedge clk);
    chk("gate_state", int'(weapon_state), 15);
    chk("gate_enable", int'(enable_weapon_collision), 0);
    chk("gate_hitbox_h", int'(hitbox_h), 0);
    chk("gate_hit_count_kept", int'(hit_count), model_hc);
    // Gate overrides a press
    attack_btn = 1'b1;
    repeat (3) @(negedge clk);
    chk("gate_blocks_press", int'(weapon_state), 15);
    attack_btn = 1'b0;
    stage = 4'hf;
    @(negedge clk);
    attack_btn = 1'b1;
    repeat (2) @(negedge clk);
    chk("gate_f_blocks_press", int'(weapon_state), 15);
    attack_btn = 1'b0;
    stage = 4'h3;
    repeat (2) @(negedge clk);

    // Async reset mid-swing clears outputs without a clock edge
    @(negedge clk);
    attack_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      attack_btn = 1'b0;
    end
    hc_before = int'(hit_count);
    chk("pre_rst_hit_count", hc_before, model_hc);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_state", int'(weapon_state), 15);
    chk("async_rst_enable", int'(enable_weapon_collision), 0);
    chk("async_rst_hitbox_h", int'(hitbox_h), 0);
    chk("async_rst_hit_count", int'(hit_count), 0);

    // Button held through reset release does not fire
    attack_btn = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("held_through_rst", int'(weapon_state), 15);
    attack_btn = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
